// File: rtl/step_dir_gen_pkg.sv
// Shared state encodings for the step/direction generator, so that the harness
// and the bench decode the FSM state the same way.
package step_dir_gen_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_STEP_HI = 3'd2;
    localparam logic [2:0] ST_STEP_LO = 3'd3;
    localparam logic [2:0] ST_FINISH  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_SETUP   = ST_SETUP,
        S_STEP_HI = ST_STEP_HI,
        S_STEP_LO = ST_STEP_LO,
        S_FINISH  = ST_FINISH
    } state_t;

endpackage

// File: rtl/step_dir_gen_step_phase_timer.sv
// Loadable down-counter shared by the setup, high and low phases.
// Loading (duration-1) makes zero assert on the last cycle of the phase.
module step_phase_timer #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/step_dir_gen.sv
// Step/direction stimulus generator driving rapcore's STEPINPUT, DIRINPUT and
// ENINPUT pins for a programmed move, counting the steps it issues.
module step_dir_gen
    import step_dir_gen_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int STEP_W = 32
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              dir,
    input  logic [STEP_W-1:0] step_count,
    input  logic [CNT_W-1:0]  pulse_width,
    input  logic [CNT_W-1:0]  step_period,
    input  logic [CNT_W-1:0]  dir_setup,
    input  logic              keep_enable,
    output logic              STEPINPUT,
    output logic              DIRINPUT,
    output logic              ENINPUT,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [STEP_W-1:0] steps_issued
);

    state_t state, next_state;

    logic [CNT_W-1:0]  pw_eff, su_eff, low_eff;
    logic [CNT_W:0]    pw_plus1;
    logic [CNT_W-1:0]  pw_q, low_q;
    logic [STEP_W-1:0] count_q, steps_q;
    logic              keep_q, abort_pend, en_q, dir_q, aborted_q;
    logic              t_load, t_zero;
    logic [CNT_W-1:0]  t_value;
    logic              accept, move_end, enter_hi;

    // Clamped timings; the low time is derived directly so the wide period never needs storing.
    always_comb begin
        pw_eff   = (pulse_width == '0) ? CNT_W'(1) : pulse_width;
        su_eff   = (dir_setup == '0) ? CNT_W'(1) : dir_setup;
        pw_plus1 = {1'b0, pw_eff} + (CNT_W+1)'(1);
        low_eff  = ({1'b0, step_period} >= pw_plus1) ? (step_period - pw_eff) : CNT_W'(1);
    end

    step_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .CLK   (CLK),
        .reset (reset),
        .load  (t_load),
        .value (t_value),
        .zero  (t_zero)
    );

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        t_load     = 1'b0;
        t_value    = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (step_count == '0) begin
                        next_state = S_FINISH;
                    end else begin
                        next_state = S_SETUP;
                        t_load     = 1'b1;
                        t_value    = su_eff - CNT_W'(1);
                    end
                end
            end
            S_SETUP: begin
                if (abort) begin
                    next_state = S_FINISH;
                end else if (t_zero) begin
                    next_state = S_STEP_HI;
                    t_load     = 1'b1;
                    t_value    = pw_q - CNT_W'(1);
                end
            end
            // An abort seen anywhere in the pulse only takes effect once the pulse is complete.
            S_STEP_HI: begin
                if (t_zero) begin
                    if (abort || abort_pend) begin
                        next_state = S_FINISH;
                    end else begin
                        next_state = S_STEP_LO;
                        t_load     = 1'b1;
                        t_value    = low_q - CNT_W'(1);
                    end
                end
            end
            S_STEP_LO: begin
                if (abort) begin
                    next_state = S_FINISH;
                end else if (t_zero) begin
                    if (steps_q < count_q) begin
                        next_state = S_STEP_HI;
                        t_load     = 1'b1;
                        t_value    = pw_q - CNT_W'(1);
                    end else begin
                        next_state = S_FINISH;
                    end
                end
            end
            S_FINISH: next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    assign accept   = (state == S_IDLE) && start;
    assign move_end = (next_state == S_FINISH) && (state != S_IDLE);
    assign enter_hi = (next_state == S_STEP_HI) && (state != S_STEP_HI);

    // A zero-step move leaves the enable and direction pins exactly as they were.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            pw_q       <= '0;
            low_q      <= '0;
            count_q    <= '0;
            keep_q     <= 1'b0;
            steps_q    <= '0;
            aborted_q  <= 1'b0;
            abort_pend <= 1'b0;
            en_q       <= 1'b0;
            dir_q      <= 1'b0;
        end else begin
            if (accept) begin
                pw_q       <= pw_eff;
                low_q      <= low_eff;
                count_q    <= step_count;
                keep_q     <= keep_enable;
                steps_q    <= '0;
                aborted_q  <= 1'b0;
                abort_pend <= 1'b0;
                if (step_count != '0) begin
                    en_q  <= 1'b1;
                    dir_q <= dir;
                end
            end
            if ((state == S_STEP_HI) && abort) begin
                abort_pend <= 1'b1;
            end
            if (enter_hi && (steps_q != '1)) begin
                steps_q <= steps_q + STEP_W'(1);
            end
            if (move_end) begin
                en_q      <= keep_q;
                aborted_q <= abort || abort_pend;
            end
        end
    end

    assign STEPINPUT    = (state == S_STEP_HI);
    assign busy         = (state == S_SETUP) || (state == S_STEP_HI) || (state == S_STEP_LO);
    assign done         = (state == S_FINISH);
    assign ENINPUT      = en_q;
    assign DIRINPUT     = dir_q;
    assign aborted      = aborted_q;
    assign steps_issued = steps_q;

endmodule

// File: doc/step_dir_gen.md
Name: step_dir_gen

Overview:
Synthesizable step/direction stimulus generator that drives rapcore's STEPINPUT, DIRINPUT and ENINPUT pins. It executes a programmed move: a step count with set pulse width, period and direction setup time. It sits directly upstream of rapcore, as a harness-side source in the testbench top or as an on-chip exerciser. It also counts issued steps so the bench can compare them against rapcore's step and encoder accounting.

Parameters:
CNT_W, 16, width of all cycle-count timing inputs and internal timer
STEP_W, 32, width of step_count and steps_issued

Ports:
CLK  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to begin a move; honoured only in IDLE
abort  input  1  level; terminates the move early (see Behaviour)
dir  input  1  requested direction, latched on start
step_count  input  STEP_W  number of step pulses to issue
pulse_width  input  CNT_W  STEP high time in cycles
step_period  input  CNT_W  STEP rising-edge-to-rising-edge time in cycles
dir_setup  input  CNT_W  cycles from ENINPUT/DIRINPUT valid to first STEP rise
keep_enable  input  1  keep ENINPUT asserted after the move completes
STEPINPUT  output  1  step pulse to rapcore
DIRINPUT  output  1  direction to rapcore
ENINPUT  output  1  enable to rapcore, active-high
busy  output  1  high from the cycle after start until done
done  output  1  one-cycle pulse at move end
aborted  output  1  sticky; set when a move ends via abort, cleared on next accepted start
steps_issued  output  STEP_W  count of STEP rising edges in the current move

Behaviour:
- Reset (async, any state) forces state IDLE and sets all outputs to 0. This includes ENINPUT and DIRINPUT, even mid-pulse.
- Inputs are latched on an accepted start. Changes during the move are ignored, except abort.
- Effective values: pw = max(pulse_width,1); per = max(step_period, pw+1); su = max(dir_setup,1).
- FSM states: IDLE, SETUP, STEP_HI, STEP_LO, FINISH.
- IDLE:
  - start with step_count=0: FINISH next cycle. ENINPUT and DIRINPUT are unchanged.
  - start with step_count>0: next cycle busy=1, ENINPUT=1, DIRINPUT=dir, steps_issued=0, aborted=0, then SETUP.
  - start while not IDLE is ignored.
- SETUP: lasts su cycles, then STEP_HI.
- STEP_HI:
  - STEPINPUT=1 for exactly pw cycles.
  - steps_issued increments in the first cycle of STEP_HI.
  - Then STEP_LO.
- STEP_LO:
  - STEPINPUT=0 for per-pw cycles.
  - Then STEP_HI if steps_issued < step_count, else FINISH.
- FINISH: lasts one cycle.
  - done=1 and busy=0 in that cycle.
  - ENINPUT keeps the value of keep_enable (as latched); DIRINPUT holds its value.
  - Next state IDLE.
- First STEP rise occurs su+1 cycles after the start cycle. Consecutive rises are exactly per cycles apart.
- Abort handling:
  - Sampled each cycle in SETUP, STEP_HI and STEP_LO.
  - In STEP_HI, the current pulse completes its full pw (no runt pulse), then FINISH.
  - In SETUP or STEP_LO, the next state is FINISH.
  - aborted=1 is set with done.
  - Abort in IDLE has no effect.
- A start in the same cycle as done/FINISH is ignored; start is accepted only in IDLE.
- Timer: a single CNT_W down-counter loaded on each state entry with (duration-1). The state advances when it reaches 0. Arithmetic is unsigned. per-pw cannot underflow because of the clamp.
- steps_issued saturates at the all-ones value. It cannot actually exceed step_count.

Decomposition:
- State encodings (5 localparams, 3-bit) go in a shared header alongside the existing constants file, so that harness and bench decode the state identically.
- One natural sub-module: step_phase_timer. It is a CNT_W loadable down-counter with inputs load/value and output zero flag, reused for setup, high and low phases.

Test Plan:
1. Basic move: step_count=3, pulse_width=2, step_period=5, dir_setup=4, dir=1, keep_enable=0; start at cycle 0.
   - ENINPUT and DIRINPUT =1 from cycle 1.
   - STEP rises at cycles 5, 10 and 15, each high 2 cycles.
   - done at cycle 20; ENINPUT=0 at cycle 20; steps_issued=3.
2. Clamping: pulse_width=0, step_period=0, dir_setup=0, step_count=2.
   - Gives pw=1, per=2, su=1.
   - STEP rises at cycles 2 and 4; done at cycle 6.
3. Zero steps: step_count=0, start.
   - done at cycle 1, busy never high, STEP never toggles, steps_issued=0.
4. Abort mid-pulse: the case 1 config with abort asserted at cycle 11 (inside the second pulse).
   - Pulse stays high through cycle 11 then falls.
   - done at cycle 12 with aborted=1 and steps_issued=2.
5. Reset mid-operation: assert reset at cycle 6 (STEP high) of case 1.
   - STEPINPUT, ENINPUT, DIRINPUT, busy and steps_issued are 0 immediately, without a clock edge.
   - A new start after reset release runs case 1 timing from the start.
6. Ignored start and keep_enable: keep_enable=1, step_count=2; pulse start again at cycle 3.
   - The second start has no effect; exactly 2 steps are issued.
   - ENINPUT remains 1 after done.
